// File: rtl/axi_burst_scheduler_if.sv
// axi_burst_scheduler_if -- AXI4 address/response channels used by the
// burst scheduler (no data payload; W data is muxed externally via gnt_id).
//   master modport : scheduler side (drives AW/AR valid+addr+len, B/R ready)
//   slave modport  : memory side    (drives AW/AR ready, B/R valid+resp, rlast)
interface axi_burst_scheduler_if #(
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] m_awaddr;
    logic [7:0]            m_awlen;
    logic                  m_awvalid;
    logic                  m_awready;
    logic                  m_bvalid;
    logic [1:0]            m_bresp;
    logic                  m_bready;
    logic [ADDR_WIDTH-1:0] m_araddr;
    logic [7:0]            m_arlen;
    logic                  m_arvalid;
    logic                  m_arready;
    logic                  m_rvalid;
    logic                  m_rlast;
    logic [1:0]            m_rresp;
    logic                  m_rready;

    modport master (
        output m_awaddr, m_awlen, m_awvalid, m_bready,
        output m_araddr, m_arlen, m_arvalid, m_rready,
        input  m_awready, m_bvalid, m_bresp,
        input  m_arready, m_rvalid, m_rlast, m_rresp
    );

    modport slave (
        input  m_awaddr, m_awlen, m_awvalid, m_bready,
        input  m_araddr, m_arlen, m_arvalid, m_rready,
        output m_awready, m_bvalid, m_bresp,
        output m_arready, m_rvalid, m_rlast, m_rresp
    );
endinterface

// File: rtl/axi_burst_scheduler.sv
// axi_burst_scheduler -- two-requester round-robin AXI4 burst scheduler with
// one burst outstanding at a time and a per-state wait timeout.
//   ACLK, ARESET           : clock, synchronous active-high reset
//   req_valid/write/addr/len: per-requester burst request (slice i = requester i)
//   req_ack                : one-cycle grant pulse (combinational in IDLE)
//   done/done_resp         : one-cycle completion pulse + status (00/10/11)
//   gnt_id, busy           : current owner, non-IDLE indicator
//   m                      : AXI AW/B/AR/R channels (master modport)
module axi_burst_scheduler #(
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 1024
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic [1:0]              req_valid,
    input  logic [1:0]              req_write,
    input  logic [2*ADDR_WIDTH-1:0] req_addr,
    input  logic [15:0]             req_len,
    output logic [1:0]              req_ack,
    output logic [1:0]              done,
    output logic [1:0]              done_resp,
    output logic                    gnt_id,
    output logic                    busy,
    axi_burst_scheduler_if.master   m
);
    localparam int WW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, ADDR, WDATA, RDATA, DONE} state_t;

    state_t                state_q, state_d;
    logic                  gnt_q, gnt_d;
    logic                  rr_q, rr_d;       // last granted requester
    logic                  dir_q, dir_d;     // 1 = write
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            len_q, len_d;
    logic [7:0]            beats_q, beats_d;
    logic [WW-1:0]         wait_q, wait_d;
    logic                  slverr_q, slverr_d;
    logic                  proto_q, proto_d; // timeout or rlast protocol error

    logic any_req, win, tmo;
    logic unused_resp_lsb;

    assign unused_resp_lsb = ^{m.m_bresp[0], m.m_rresp[0]};

    assign any_req = |req_valid;
    // On a tie the requester that was not granted last wins.
    assign win     = (req_valid == 2'b11) ? ~rr_q : req_valid[1];
    assign tmo     = (wait_q == WW'(TIMEOUT));

    assign busy       = (state_q != IDLE);
    assign gnt_id     = (state_q == IDLE && any_req && !ARESET) ? win : gnt_q;
    assign m.m_awaddr = addr_q;
    assign m.m_awlen  = len_q;
    assign m.m_araddr = addr_q;
    assign m.m_arlen  = len_q;

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        rr_d        = rr_q;
        dir_d       = dir_q;
        addr_d      = addr_q;
        len_d       = len_q;
        beats_d     = beats_q;
        slverr_d    = slverr_q;
        proto_d     = proto_q;
        req_ack     = 2'b00;
        done        = 2'b00;
        done_resp   = 2'b00;
        m.m_awvalid = 1'b0;
        m.m_arvalid = 1'b0;
        m.m_bready  = 1'b0;
        m.m_rready  = 1'b0;

        case (state_q)
            IDLE: begin
                if (any_req && !ARESET) begin
                    req_ack[win] = 1'b1;
                    gnt_d        = win;
                    rr_d         = win;
                    dir_d        = req_write[win];
                    addr_d       = win ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                                       : req_addr[ADDR_WIDTH-1:0];
                    len_d        = win ? req_len[15:8] : req_len[7:0];
                    beats_d      = 8'd0;
                    slverr_d     = 1'b0;
                    proto_d      = 1'b0;
                    state_d      = ADDR;
                end
            end
            ADDR: begin
                if (tmo) begin
                    proto_d = 1'b1;
                    state_d = DONE;
                end else if (dir_q) begin
                    m.m_awvalid = 1'b1;
                    if (m.m_awready) state_d = WDATA;
                end else begin
                    m.m_arvalid = 1'b1;
                    if (m.m_arready) state_d = RDATA;
                end
            end
            WDATA: begin
                if (tmo) begin
                    proto_d = 1'b1;
                    state_d = DONE;
                end else begin
                    m.m_bready = 1'b1;
                    if (m.m_bvalid) begin
                        slverr_d = m.m_bresp[1];
                        state_d  = DONE;
                    end
                end
            end
            RDATA: begin
                if (tmo) begin
                    proto_d = 1'b1;
                    state_d = DONE;
                end else begin
                    m.m_rready = 1'b1;
                    if (m.m_rvalid) begin
                        if (m.m_rresp[1]) slverr_d = 1'b1;
                        if (m.m_rlast) begin
                            if (beats_q != len_q) proto_d = 1'b1;
                            state_d = DONE;
                        end else begin
                            // Final beat index without rlast: flag it, keep
                            // draining until the slave does send rlast.
                            if (beats_q == len_q) proto_d = 1'b1;
                            beats_d = beats_q + 8'd1;
                        end
                    end
                end
            end
            DONE: begin
                done[gnt_q] = 1'b1;
                done_resp   = proto_q ? 2'b11 : (slverr_q ? 2'b10 : 2'b00);
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (state_d != state_q || state_q == IDLE || state_q == DONE)
            wait_d = '0;
        else
            wait_d = wait_q + WW'(1);
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q  <= IDLE;
            gnt_q    <= 1'b0;
            rr_q     <= 1'b1;
            dir_q    <= 1'b0;
            addr_q   <= '0;
            len_q    <= 8'd0;
            beats_q  <= 8'd0;
            wait_q   <= '0;
            slverr_q <= 1'b0;
            proto_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            rr_q     <= rr_d;
            dir_q    <= dir_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            beats_q  <= beats_d;
            wait_q   <= wait_d;
            slverr_q <= slverr_d;
            proto_q  <= proto_d;
        end
    end
endmodule

// File: tb/tb_axi_burst_scheduler.sv
// tb_axi_burst_scheduler -- vector table of single bursts plus hand-written
// timeout, arbitration and mid-burst reset sequences; completions are
// checked against a queue of expected {requester, response} records.
module tb_axi_burst_scheduler;
    localparam int AW  = 32;
    localparam int TMO = 16;

    logic            ACLK = 1'b0;
    logic            ARESET;
    logic [1:0]      req_valid, req_write, req_ack, done, done_resp;
    logic [2*AW-1:0] req_addr;
    logic [15:0]     req_len;
    logic            gnt_id, busy;

    axi_burst_scheduler_if #(.ADDR_WIDTH(AW)) m_if();

    axi_burst_scheduler #(.ADDR_WIDTH(AW), .TIMEOUT(TMO)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_len(req_len),
        .req_ack(req_ack), .done(done), .done_resp(done_resp),
        .gnt_id(gnt_id), .busy(busy), .m(m_if)
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        logic       id;
        logic [1:0] resp;
    } exp_t;

    typedef struct {
        logic        id;
        logic        wr;
        logic [31:0] addr;
        logic [7:0]  len;
        int          nbeats;
        int          rlast_at;
        int          err_beat;
        logic [1:0]  bresp;
        int          aw_delay;
        logic [1:0]  exp;
    } vec_t;

    exp_t exp_q[$];
    exp_t mon_e;
    vec_t vecs[8];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic set_req(input logic id, input logic v, input logic w,
                           input logic [31:0] a, input logic [7:0] l);
        if (id == 1'b0) begin
            req_valid[0] = v; req_write[0] = w; req_addr[31:0] = a; req_len[7:0] = l;
        end else begin
            req_valid[1] = v; req_write[1] = w; req_addr[63:32] = a; req_len[15:8] = l;
        end
    endtask

    task automatic chk_zero(input string name);
        chk(name, 64'({req_ack, done, done_resp, gnt_id, busy,
                       m_if.m_awvalid, m_if.m_arvalid, m_if.m_bready, m_if.m_rready,
                       m_if.m_awlen, m_if.m_arlen}), 64'd0);
        chk({name, "_addr"}, {m_if.m_awaddr, m_if.m_araddr}, 64'd0);
    endtask

    // Granted write with an always-ready slave and OKAY response; entered at
    // the start of the ADDR cycle, returns at the start of the next IDLE cycle.
    task automatic serve_write();
        m_if.m_awready = 1'b1;
        @(negedge ACLK);
        chk("sw_awvalid", 64'(m_if.m_awvalid), 64'd1);
        tick();
        m_if.m_awready = 1'b0;
        m_if.m_bvalid  = 1'b1;
        m_if.m_bresp   = 2'b00;
        @(negedge ACLK);
        chk("sw_bready", 64'(m_if.m_bready), 64'd1);
        tick();
        m_if.m_bvalid = 1'b0;
        @(negedge ACLK);
        chk("sw_done", 64'(|done), 64'd1);
        tick();
    endtask

    task automatic run_burst(input vec_t v);
        logic [1:0] ea;
        ea = v.id ? 2'b10 : 2'b01;
        exp_q.push_back('{id: v.id, resp: v.exp});
        set_req(v.id, 1'b1, v.wr, v.addr, v.len);
        @(negedge ACLK);
        chk("ack", 64'({gnt_id, req_ack}), 64'({v.id, ea}));
        tick();
        req_valid = 2'b00;
        repeat (v.aw_delay) begin
            @(negedge ACLK);
            chk("addr_hold", 64'({m_if.m_awvalid, m_if.m_arvalid}), 64'(v.wr ? 2'b10 : 2'b01));
            tick();
        end
        @(negedge ACLK);
        if (v.wr) begin
            chk("aw", 64'({m_if.m_awvalid, m_if.m_arvalid, m_if.m_awaddr, m_if.m_awlen}),
                64'({2'b10, v.addr, v.len}));
            m_if.m_awready = 1'b1;
        end else begin
            chk("ar", 64'({m_if.m_awvalid, m_if.m_arvalid, m_if.m_araddr, m_if.m_arlen}),
                64'({2'b01, v.addr, v.len}));
            m_if.m_arready = 1'b1;
        end
        tick();
        m_if.m_awready = 1'b0;
        m_if.m_arready = 1'b0;
        if (v.wr) begin
            m_if.m_bvalid = 1'b1;
            m_if.m_bresp  = v.bresp;
            @(negedge ACLK);
            chk("bready", 64'({m_if.m_bready, m_if.m_rready}), 64'(2'b10));
            tick();
            m_if.m_bvalid = 1'b0;
            m_if.m_bresp  = 2'b00;
        end else begin
            for (int b = 0; b < v.nbeats; b++) begin
                m_if.m_rvalid = 1'b1;
                m_if.m_rlast  = (b == v.rlast_at);
                m_if.m_rresp  = (b == v.err_beat) ? 2'b10 : 2'b00;
                @(negedge ACLK);
                chk("rready", 64'({m_if.m_rready, m_if.m_bready}), 64'(2'b10));
                tick();
            end
            m_if.m_rvalid = 1'b0;
            m_if.m_rlast  = 1'b0;
            m_if.m_rresp  = 2'b00;
        end
        @(negedge ACLK);
        chk("done_lat", 64'(done), 64'(ea));
        tick();
        @(negedge ACLK);
        chk("idle_after", 64'(busy), 64'd0);
        tick();
    endtask

    // Scoreboard: every done pulse must match the oldest expectation.
    always @(negedge ACLK) begin
        if (|done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 64'(done), 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("done_resp", 64'({done, done_resp}),
                    64'({(mon_e.id ? 2'b10 : 2'b01), mon_e.resp}));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        //          id  wr  addr           len  nb  rl  err bresp dly exp
        vecs[0] = '{1'b0, 1'b1, 32'h0000_0000, 8'd7,   0, -1, -1, 2'b00, 0, 2'b00};
        vecs[1] = '{1'b0, 1'b0, 32'h0000_1000, 8'd7,   8,  7, -1, 2'b00, 0, 2'b00};
        vecs[2] = '{1'b1, 1'b1, 32'hDEAD_BEE0, 8'd3,   0, -1, -1, 2'b10, 2, 2'b10};
        vecs[3] = '{1'b1, 1'b0, 32'h0000_2000, 8'd7,   4,  3, -1, 2'b00, 0, 2'b11};
        vecs[4] = '{1'b0, 1'b0, 32'h0000_3000, 8'd7,   8,  7,  2, 2'b00, 1, 2'b10};
        vecs[5] = '{1'b1, 1'b0, 32'h0000_4000, 8'd3,   6,  5, -1, 2'b00, 0, 2'b11};
        vecs[6] = '{1'b0, 1'b1, 32'hFFFF_FFFC, 8'd255, 0, -1, -1, 2'b11, 5, 2'b10};
        vecs[7] = '{1'b1, 1'b0, 32'h1234_5678, 8'd0,   1,  0, -1, 2'b00, 0, 2'b00};

        ARESET = 1'b1;
        req_valid = 2'b00; req_write = 2'b00; req_addr = '0; req_len = '0;
        m_if.m_awready = 1'b0; m_if.m_bvalid = 1'b0; m_if.m_bresp = 2'b00;
        m_if.m_arready = 1'b0; m_if.m_rvalid = 1'b0; m_if.m_rlast = 1'b0;
        m_if.m_rresp   = 2'b00;
        tick();
        tick();
        @(negedge ACLK);
        chk_zero("reset");
        tick();
        ARESET = 1'b0;

        foreach (vecs[i]) run_burst(vecs[i]);

        // AW never accepted: awvalid for exactly TMO cycles, then abort with 11.
        exp_q.push_back('{id: 1'b1, resp: 2'b11});
        set_req(1'b1, 1'b1, 1'b1, 32'h0000_0040, 8'd1);
        @(negedge ACLK);
        chk("tmo_ack", 64'({gnt_id, req_ack}), 64'(3'b110));
        tick();
        req_valid = 2'b00;
        cnt = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge ACLK);
            if (!m_if.m_awvalid) break;
            cnt++;
            tick();
        end
        chk("tmo_cycles", 64'(cnt), 64'(TMO));
        chk("tmo_busy", 64'(busy), 64'd1);
        tick();
        @(negedge ACLK);
        chk("tmo_done", 64'(done), 64'(2'b10));
        tick();
        @(negedge ACLK);
        chk("tmo_idle", 64'(busy), 64'd0);
        tick();

        // Both requesters held: grants must alternate 0,1,0,1.
        req_valid = 2'b11; req_write = 2'b11;
        req_addr = {32'h0000_B000, 32'h0000_A000}; req_len = {8'd2, 8'd1};
        for (int i = 0; i < 4; i++) begin
            @(negedge ACLK);
            chk("rr_ack", 64'({gnt_id, req_ack}),
                64'(((i % 2) == 1) ? 3'b110 : 3'b001));
            exp_q.push_back('{id: ((i % 2) == 1), resp: 2'b00});
            tick();
            req_valid[i % 2] = 1'b0;
            serve_write();
            req_valid[i % 2] = 1'b1;
        end
        req_valid = 2'b00;

        // Reset in the middle of a read: no done, everything back to zero,
        // round-robin pointer back to favouring requester 0.
        set_req(1'b0, 1'b1, 1'b0, 32'h0000_5500, 8'd7);
        @(negedge ACLK);
        chk("rst_ack", 64'(req_ack), 64'(2'b01));
        tick();
        req_valid = 2'b00;
        m_if.m_arready = 1'b1;
        @(negedge ACLK);
        tick();
        m_if.m_arready = 1'b0;
        m_if.m_rvalid  = 1'b1;
        repeat (2) begin
            @(negedge ACLK);
            tick();
        end
        ARESET = 1'b1;
        @(negedge ACLK);
        chk("rst_pre_busy", 64'(busy), 64'd1);
        tick();
        m_if.m_rvalid = 1'b0;
        @(negedge ACLK);
        chk_zero("rst_mid");
        tick();
        ARESET = 1'b0;
        repeat (3) begin
            @(negedge ACLK);
            chk("rst_no_done", 64'({done, busy}), 64'd0);
            tick();
        end
        req_valid = 2'b11; req_write = 2'b11;
        @(negedge ACLK);
        chk("rst_rr", 64'({gnt_id, req_ack}), 64'(3'b001));
        exp_q.push_back('{id: 1'b0, resp: 2'b00});
        tick();
        req_valid = 2'b00;
        serve_write();

        repeat (2) tick();
        chk("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/axi_burst_scheduler.md
AXI_BURST_SCHEDULER -- requirements
Module: axi_burst_scheduler

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, AXI address width.
REQ-002 SHALL have parameter TIMEOUT, default 1024, maximum cycles allowed in any wait state before abort.
REQ-003 SHALL have port ACLK  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port ARESET  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  2  per-requester burst request, held until req_ack.
REQ-006 SHALL have port req_write  input  2  per-requester direction: 1 write, 0 read.
REQ-007 SHALL have port req_addr  input  2*ADDR_WIDTH  per-requester start address; requester i uses slice i.
REQ-008 SHALL have port req_len  input  16  per-requester AXI length (beats-1); slice [8i+:8].
REQ-009 SHALL have port req_ack  output  2  one-cycle pulse when the request is granted.
REQ-010 SHALL have port done  output  2  one-cycle pulse when the granted burst completes.
REQ-011 SHALL have port done_resp  output  2  completion status, valid with done: 00 OKAY, 10 SLVERR, 11 timeout/protocol error.
REQ-012 SHALL have port gnt_id  output  1  index of the current owner, used externally to mux the W channel.
REQ-013 SHALL have port busy  output  1  high in every state except IDLE.
REQ-014 SHALL have ports m_awaddr/m_awlen/m_awvalid  output  ADDR_WIDTH/8/1  AXI4 write-address channel.
REQ-015 SHALL have ports m_awready, m_bvalid  input  1; m_bresp  input  2; m_bready  output  1.
REQ-016 SHALL have ports m_araddr/m_arlen/m_arvalid  output  ADDR_WIDTH/8/1  AXI4 read-address channel.
REQ-017 SHALL have ports m_arready, m_rvalid, m_rlast  input  1; m_rresp  input  2; m_rready  output  1.

Function
REQ-018 SHALL use an FSM with states IDLE, ADDR, WDATA, RDATA and DONE; at most one burst outstanding.
REQ-019 SHALL arbitrate round-robin in IDLE: the last-granted requester has lowest priority; after reset requester 0 wins a tie.
REQ-020 SHALL, in IDLE with any req_valid, register gnt_id, addr, len and dir, pulse req_ack[gnt_id] and enter ADDR next cycle.
REQ-021 SHALL, in ADDR, hold m_awvalid (write) or m_arvalid (read) high with registered addr/len until ready is seen, then enter WDATA (write) or RDATA (read).
REQ-022 SHALL keep m_awaddr/m_awlen/m_araddr/m_arlen stable while the corresponding valid is high.
REQ-023 SHALL, in WDATA, hold m_bready=1 and enter DONE on m_bvalid, capturing m_bresp[1] as error.
REQ-024 SHALL, in RDATA, hold m_rready=1, count m_rvalid beats in an 8-bit counter, OR any m_rresp[1] into an error flag, and enter DONE on m_rvalid&m_rlast.
REQ-025 SHALL report 11 if m_rlast arrives at a beat index other than len, or if len+1 beats pass without m_rlast; in the latter case it SHALL continue waiting for m_rlast.
REQ-026 SHALL run a wait counter that clears on every state change; when it reaches TIMEOUT in ADDR/WDATA/RDATA it SHALL deassert all valid/ready outputs, enter DONE and report 11.
REQ-027 SHALL, in DONE, pulse done[gnt_id] with done_resp for one cycle and return to IDLE; the earliest new grant is the following cycle.
REQ-028 SHALL ignore req_valid changes while busy; a request dropped before ack is never granted.
REQ-029 SHALL keep m_bready and m_rready low outside WDATA/RDATA.

Reset
REQ-030 SHALL, on ARESET, go to IDLE and drive all outputs to 0, with round-robin pointer favouring requester 0 and counters cleared.
REQ-031 SHALL, when ARESET arrives mid-burst, abandon the burst without a done pulse; reset takes priority over every other event.

Verification
REQ-032 SHALL cover: req0 write, addr 0x0, len 7; slave accepts AW and returns BRESP 00 -> ack0 at cycle 1, awvalid at cycle 2, done0 with resp 00.
REQ-033 SHALL cover: req0 read, len 7; 8 beats with rlast on beat 8 -> done0 with resp 00 one cycle after the last beat.
REQ-034 SHALL cover: req0 and req1 valid in the same cycle, twice -> grant order 0, 1, then 0, 1, with gnt_id matching each ack.
REQ-035 SHALL cover: read len 7 with rlast on beat 4 -> done with resp 11; read with rresp 10 on beat 3 -> resp 10.
REQ-036 SHALL cover: awready held low for TIMEOUT=16 cycles -> awvalid drops, done pulses with resp 11 and busy clears.
REQ-037 SHALL cover: ARESET asserted during RDATA -> next cycle busy=0 and all outputs 0, with no done pulse.
